// File: rtl/mmu_req_arbiter.sv
// Round-robin arbiter that shares one simple_mmu translation port among NUM_REQ requesters.
// Optional response watchdog (timeout fault + DRAIN state) is enabled by defining MMU_ARB_TIMEOUT_EN.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef MMU_STATUS_HIT
`define MMU_STATUS_HIT 2'b00
`endif
`ifndef MMU_STATUS_MISS
`define MMU_STATUS_MISS 2'b01
`endif
`ifndef MMU_STATUS_PAGE_FAULT
`define MMU_STATUS_PAGE_FAULT 2'b10
`endif

module mmu_req_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int REQ_IDX_W      = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*`ADDR_WIDTH-1:0]  req_va,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              resp_valid,
    output logic [`ADDR_WIDTH-1:0]          resp_pa,
    output logic [1:0]                      resp_status,
    input  logic [NUM_REQ-1:0]              resp_ready,
    output logic                            m_req_valid,
    output logic [`ADDR_WIDTH-1:0]          m_req_va,
    input  logic                            m_req_ready,
    input  logic                            m_resp_valid,
    input  logic [`ADDR_WIDTH-1:0]          m_resp_pa,
    input  logic [1:0]                      m_resp_status,
    output logic                            m_resp_ready,
    output logic                            busy
);

    localparam int AW     = `ADDR_WIDTH;
    localparam int IDXP_W = REQ_IDX_W + 1;
`ifdef MMU_ARB_TIMEOUT_EN
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
`endif

    if (NUM_REQ < 2 || NUM_REQ > 8 || REQ_IDX_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("mmu_req_arbiter: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
`ifdef MMU_ARB_TIMEOUT_EN
        , ST_DRAIN = 2'd3
`endif
    } state_e;

    state_e                 state_q, state_d;
    logic [REQ_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [REQ_IDX_W-1:0]   owner_q, owner_d;
    logic [AW-1:0]          held_va_q, held_va_d;
`ifdef MMU_ARB_TIMEOUT_EN
    logic [WD_W-1:0]        wdog_q, wdog_d;
    logic                   to_flag_q, to_flag_d;
`endif

    logic [NUM_REQ-1:0]     rot_valid_s;
    logic                   any_valid_s;
    logic [REQ_IDX_W-1:0]   winner_s;
    logic [IDXP_W-1:0]      sum_s;
    logic [AW-1:0]          winner_va_s;
    logic [NUM_REQ-1:0]     winner_oh_s;
    logic [NUM_REQ-1:0]     owner_oh_s;
    logic                   owner_rdy_s;
    logic [REQ_IDX_W-1:0]   next_ptr_s;

    assign winner_oh_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
    assign owner_oh_s  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign owner_rdy_s = |(resp_ready & owner_oh_s);
    assign next_ptr_s  = (owner_q == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : (owner_q + REQ_IDX_W'(1));
    assign busy        = (state_q != ST_IDLE);

    // Round-robin pick: rotate valids so bit 0 is the rr_ptr requester; lowest set bit wins.
    always_comb begin
        rot_valid_s = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
        any_valid_s = |req_valid;
        winner_s    = rr_ptr_q;
        sum_s       = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum_s    = {1'b0, rr_ptr_q} + IDXP_W'(i);
            sum_s    = (sum_s >= IDXP_W'(NUM_REQ)) ? (sum_s - IDXP_W'(NUM_REQ)) : sum_s;
            winner_s = rot_valid_s[i] ? sum_s[REQ_IDX_W-1:0] : winner_s;
        end
    end

    // Select the winner's VA slice from the packed request bus.
    always_comb begin
        winner_va_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            winner_va_s = (winner_s == REQ_IDX_W'(i)) ? req_va[i*AW +: AW] : winner_va_s;
        end
    end

    // Next-state and output decode; response path is a combinational pass-through in WAIT.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        held_va_d    = held_va_q;
        req_ready    = '0;
        resp_valid   = '0;
        resp_pa      = '0;
        resp_status  = `MMU_STATUS_HIT;
        m_req_valid  = 1'b0;
        m_req_va     = '0;
        m_resp_ready = 1'b0;
`ifdef MMU_ARB_TIMEOUT_EN
        wdog_d       = wdog_q;
        to_flag_d    = to_flag_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_valid_s) begin
                    req_ready = winner_oh_s;
                    held_va_d = winner_va_s;
                    owner_d   = winner_s;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                m_req_valid = 1'b1;
                m_req_va    = held_va_q;
                if (m_req_ready) begin
                    state_d   = ST_WAIT;
`ifdef MMU_ARB_TIMEOUT_EN
                    wdog_d    = '0;
                    to_flag_d = 1'b0;
`endif
                end else begin
                    state_d   = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                resp_valid   = m_resp_valid ? owner_oh_s : '0;
                resp_pa      = m_resp_pa;
                resp_status  = m_resp_status;
                m_resp_ready = owner_rdy_s;
                if (m_resp_valid && owner_rdy_s) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr_s;
                end else begin
                    state_d  = ST_WAIT;
                end
`ifdef MMU_ARB_TIMEOUT_EN
                // A synthetic fault response overrides the pass-through once the watchdog fires.
                if (to_flag_q) begin
                    resp_valid   = owner_oh_s;
                    resp_pa      = '0;
                    resp_status  = `MMU_STATUS_PAGE_FAULT;
                    m_resp_ready = 1'b0;
                    rr_ptr_d     = rr_ptr_q;
                    state_d      = owner_rdy_s ? ST_DRAIN : ST_WAIT;
                end else if (!m_resp_valid) begin
                    wdog_d    = wdog_q + WD_W'(1);
                    to_flag_d = (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
                end else begin
                    wdog_d    = wdog_q;
                end
`endif
            end
`ifdef MMU_ARB_TIMEOUT_EN
            ST_DRAIN: begin
                m_resp_ready = 1'b1;
                if (m_resp_valid) begin
                    state_d   = ST_IDLE;
                    rr_ptr_d  = next_ptr_s;
                    to_flag_d = 1'b0;
                end else begin
                    state_d   = ST_DRAIN;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; an asynchronous reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            held_va_q <= '0;
`ifdef MMU_ARB_TIMEOUT_EN
            wdog_q    <= '0;
            to_flag_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            held_va_q <= held_va_d;
`ifdef MMU_ARB_TIMEOUT_EN
            wdog_q    <= wdog_d;
            to_flag_q <= to_flag_d;
`endif
        end
    end

endmodule

// File: tb/tb_mmu_req_arbiter.sv
// Randomised self-checking bench for mmu_req_arbiter with a behavioural MMU stand-in and
// a transaction-level round-robin reference model.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef MMU_STATUS_HIT
`define MMU_STATUS_HIT 2'b00
`endif
`ifndef MMU_STATUS_MISS
`define MMU_STATUS_MISS 2'b01
`endif
`ifndef MMU_STATUS_PAGE_FAULT
`define MMU_STATUS_PAGE_FAULT 2'b10
`endif

module tb_mmu_req_arbiter;

    localparam int N  = 2;
    localparam int IW = 1;
    localparam int AW = `ADDR_WIDTH;
    localparam logic [1:0] S_HIT  = `MMU_STATUS_HIT;
    localparam logic [1:0] S_MISS = `MMU_STATUS_MISS;
    localparam logic [1:0] S_PF   = `MMU_STATUS_PAGE_FAULT;
    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
    logic [N*AW-1:0] req_va;
    logic [AW-1:0]   resp_pa, m_req_va, m_resp_pa;
    logic [1:0]      resp_status, m_resp_status;
    logic            m_req_valid, m_req_ready, m_resp_valid, m_resp_ready, busy;

    mmu_req_arbiter #(.NUM_REQ(N), .REQ_IDX_W(IW), .TIMEOUT_CYCLES(64)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_va(req_va), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_pa(resp_pa), .resp_status(resp_status),
        .resp_ready(resp_ready),
        .m_req_valid(m_req_valid), .m_req_va(m_req_va), .m_req_ready(m_req_ready),
        .m_resp_valid(m_resp_valid), .m_resp_pa(m_resp_pa), .m_resp_status(m_resp_status),
        .m_resp_ready(m_resp_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Per-requester pending VA lists
    logic [AW-1:0] va_list[N][128];
    int            head[N];
    int            tail[N];

    // Reference model state (transaction level)
    int            rr_m;
    bit            outst_m;
    bit            issued_m;
    int            owner_m;
    logic [AW-1:0] own_va_m;
    logic [AW-1:0] exp_pa_m;
    logic [1:0]    exp_st_m;
    bit            sb_tlb[16];
    int            grants[$];
    logic [AW-1:0] last_pa[N];
    logic [1:0]    last_st[N];
    int            n_resp;

    // MMU stand-in state
    bit            mmu_pend;
    int            mmu_cnt;
    logic [AW-1:0] mmu_pa;
    logic [1:0]    mmu_st;
    bit            mmu_tlb[16];

    // Stimulus policy
    int            rdy_mode;  // 0: always ready, 1: random, 2: held low
    bit            mmu_rand;
    bit            drop_en;

    task automatic push(input int k, input logic [AW-1:0] va);
        va_list[k][tail[k]] = va;
        tail[k]++;
    endtask

    function automatic int pick_winner(input logic [N-1:0] v, input int rr);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (rr + i) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic bit any_pending();
        for (int k = 0; k < N; k++) begin
            if (head[k] < tail[k]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            head[k] = 0;
            tail[k] = 0;
        end
        for (int v = 0; v < 16; v++) begin
            sb_tlb[v]  = 1'b0;
            mmu_tlb[v] = 1'b0;
        end
        rr_m = 0; outst_m = 1'b0; issued_m = 1'b0; owner_m = 0;
        mmu_pend = 1'b0; mmu_cnt = 0; mmu_pa = '0; mmu_st = S_HIT;
    endtask

    // One clock cycle: drive at negedge, check outputs, advance model for the next posedge
    task automatic step();
        int w;
        bit acc, iss, waiting, rsp;
        logic [N-1:0] exp_rdy, exp_rv;
        int vpn;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (head[k] < tail[k]) begin
                req_valid[k]        = drop_en ? ($urandom_range(3) != 0) : 1'b1;
                req_va[k*AW +: AW]  = va_list[k][head[k]];
            end else begin
                req_valid[k]        = 1'b0;
                req_va[k*AW +: AW]  = '0;
            end
            case (rdy_mode)
                0:       resp_ready[k] = 1'b1;
                1:       resp_ready[k] = ($urandom_range(1) == 1);
                default: resp_ready[k] = 1'b0;
            endcase
        end
        m_req_ready   = !mmu_pend && (mmu_rand ? ($urandom_range(1) == 1) : 1'b1);
        m_resp_valid  = mmu_pend && (mmu_cnt == 0);
        m_resp_pa     = m_resp_valid ? mmu_pa : AW'($urandom());
        m_resp_status = mmu_st;
        #1;
        w       = pick_winner(req_valid, rr_m);
        acc     = !outst_m && (w >= 0);
        exp_rdy = acc ? (ONE << w) : '0;
        check_eq("req_ready", req_ready, exp_rdy);
        check_eq("busy", busy, outst_m);
        check_eq("m_req_valid", m_req_valid, outst_m && !issued_m);
        if (outst_m && !issued_m) check_eq("m_req_va", m_req_va, own_va_m);
        iss     = outst_m && !issued_m && m_req_ready;
        waiting = outst_m && issued_m;
        exp_rv  = (waiting && m_resp_valid) ? (ONE << owner_m) : '0;
        check_eq("resp_valid", resp_valid, exp_rv);
        check_eq("m_resp_ready", m_resp_ready, waiting ? resp_ready[owner_m] : 1'b0);
        if (waiting && m_resp_valid) begin
            check_eq("resp_pa_pass", resp_pa, m_resp_pa);
            check_eq("resp_status_pass", resp_status, m_resp_status);
        end
        rsp = waiting && m_resp_valid && resp_ready[owner_m];
        if (rsp) begin
            check_eq("deliv_pa", resp_pa, exp_pa_m);
            check_eq("deliv_status", resp_status, exp_st_m);
            last_pa[owner_m] = resp_pa;
            last_st[owner_m] = resp_status;
            n_resp++;
            outst_m = 1'b0;
            rr_m    = (owner_m + 1) % N;
        end
        if (iss) issued_m = 1'b1;
        if (acc) begin
            owner_m  = w;
            own_va_m = va_list[w][head[w]];
            head[w]++;
            grants.push_back(w);
            outst_m  = 1'b1;
            issued_m = 1'b0;
            vpn      = int'(own_va_m[AW-1:12]);
            if (vpn >= 16) begin
                exp_pa_m = '0;
                exp_st_m = S_PF;
            end else begin
                exp_pa_m = {AW'(vpn + 10) << 12} | {20'h0, own_va_m[11:0]};
                exp_st_m = sb_tlb[vpn] ? S_HIT : S_MISS;
                sb_tlb[vpn] = 1'b1;
            end
        end
        // MMU stand-in: hit answers in the first WAIT cycle, miss/fault after a walk
        if (m_resp_valid && m_resp_ready) begin
            mmu_pend = 1'b0;
        end else if (mmu_pend && mmu_cnt > 0) begin
            mmu_cnt--;
        end
        if (m_req_valid && m_req_ready) begin
            vpn      = int'(m_req_va[AW-1:12]);
            mmu_pend = 1'b1;
            if (vpn >= 16) begin
                mmu_pa  = '0;
                mmu_st  = S_PF;
                mmu_cnt = 3;
            end else begin
                mmu_pa  = (AW'(vpn + 10) << 12) | (m_req_va & AW'(32'h0000_0FFF));
                mmu_st  = mmu_tlb[vpn] ? S_HIT : S_MISS;
                mmu_cnt = mmu_tlb[vpn] ? 0 : 3;
                mmu_tlb[vpn] = 1'b1;
            end
            if (mmu_rand && mmu_cnt > 0) mmu_cnt = mmu_cnt + $urandom_range(2);
        end
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int c;
        c = 0;
        while ((any_pending() || outst_m) && c < budget) begin
            step();
            c++;
        end
        check_eq(tag, (any_pending() || outst_m), 1'b0);
    endtask

    // Assert reset asynchronously, check outputs, then clear inputs and model
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_req_ready", req_ready, '0);
        check_eq("rst_resp_valid", resp_valid, '0);
        check_eq("rst_resp_pa", resp_pa, '0);
        check_eq("rst_resp_status", resp_status, S_HIT);
        check_eq("rst_m_req_valid", m_req_valid, 1'b0);
        check_eq("rst_m_req_va", m_req_va, '0);
        check_eq("rst_m_resp_ready", m_resp_ready, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        req_valid = '0; req_va = '0; resp_ready = '0;
        m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_pa = '0; m_resp_status = '0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [AW-1:0] held_pa;
        int c;
        rst_n = 1'b1;
        req_valid = '0; req_va = '0; resp_ready = '0;
        m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_pa = '0; m_resp_status = '0;
        rdy_mode = 0; mmu_rand = 1'b0; drop_en = 1'b0; n_resp = 0;
        clear_model();
        apply_reset();

        // Cold miss then hit on the same VA
        push(0, 32'h0000_1234);
        run_until_idle("t1_drain", 40);
        check_eq("t1_miss_pa", last_pa[0], 32'h0000_B234);
        check_eq("t1_miss_st", last_st[0], S_MISS);
        push(0, 32'h0000_1234);
        run_until_idle("t1b_drain", 40);
        check_eq("t1_hit_pa", last_pa[0], 32'h0000_B234);
        check_eq("t1_hit_st", last_st[0], S_HIT);

        // Simultaneous requests after reset: 0 then 1
        apply_reset();
        grants.delete();
        push(0, 32'h0000_3000);
        push(1, 32'h0000_2010);
        run_until_idle("t2_drain", 60);
        check_eq("t2_n_grants", grants.size(), 2);
        check_eq("t2_first", grants[0], 0);
        check_eq("t2_second", grants[1], 1);
        check_eq("t2_pa1", last_pa[1], 32'h0000_C010);

        // Continuous contention: strict alternation
        grants.delete();
        for (int i = 0; i < 3; i++) begin
            push(0, 32'h0000_1000 + AW'(i * 16));
            push(1, 32'h0000_7000 + AW'(i * 16));
        end
        run_until_idle("t3_drain", 120);
        check_eq("t3_n_grants", grants.size(), 6);
        for (int i = 0; i < 6; i++) check_eq("t3_order", grants[i], i % 2);

        // Response backpressure holds the response and blocks new grants
        push(0, 32'h0000_4ABC);
        rdy_mode = 2;
        c = 0;
        while (!(outst_m && issued_m && m_resp_valid) && c < 40) begin
            step();
            c++;
        end
        check_eq("t4_reach_wait", (outst_m && issued_m && m_resp_valid), 1'b1);
        held_pa = resp_pa;
        check_eq("t4_pa", held_pa, 32'h0000_EABC);
        push(1, 32'h0000_5000);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t4_hold_rv", resp_valid, 2'b01);
            check_eq("t4_hold_pa", resp_pa, held_pa);
        end
        rdy_mode = 0;
        run_until_idle("t4_drain", 60);

        // Page fault delivered only to its owner
        push(1, 32'h0001_0000);
        run_until_idle("t5_drain", 40);
        check_eq("t5_pf_st", last_st[1], S_PF);
        check_eq("t5_pf_pa", last_pa[1], '0);

        // Randomised traffic
        apply_reset();
        n_resp = 0;
        rdy_mode = 1; mmu_rand = 1'b1; drop_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < N; k++) begin
                push(k, {AW'($urandom_range(18)) << 12} | AW'($urandom_range(4095)));
            end
        end
        run_until_idle("rand_drain", 4000);
        check_eq("rand_resp_count", n_resp, 80);

        // Reset while waiting for the MMU, then a fresh request from requester 1
        rdy_mode = 2; mmu_rand = 1'b0; drop_en = 1'b0;
        push(0, 32'h0000_6000);
        c = 0;
        while (!(outst_m && issued_m && m_resp_valid) && c < 40) begin
            step();
            c++;
        end
        check_eq("t6_reach_wait", (outst_m && issued_m && m_resp_valid), 1'b1);
        apply_reset();
        rdy_mode = 0;
        grants.delete();
        push(1, 32'h0000_2010);
        run_until_idle("t6_drain", 40);
        check_eq("t6_grant", grants.size() > 0 ? grants[0] : -1, 1);
        check_eq("t6_pa", last_pa[1], 32'h0000_C010);
        check_eq("t6_st", last_st[1], S_MISS);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mmu_req_arbiter.md
Name: mmu_req_arbiter

Overview:
- Round-robin arbiter that shares one simple_mmu translation port between NUM_REQ requesters, e.g. instruction-fetch and load/store units.
- Sits between the requesters and simple_mmu. Grants one requester at a time and keeps exactly one translation outstanding.
- Steers the MMU response back to the granted requester only.

Parameters:
- NUM_REQ, 2: number of requester ports; legal range 2..8.
- REQ_IDX_W, 1: width of the owner index; must equal clog2(NUM_REQ).
- TIMEOUT_CYCLES, 64: response watchdog limit; used only with MMU_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_va  in  NUM_REQ*`ADDR_WIDTH  packed VAs; requester k occupies slice [k*`ADDR_WIDTH +: `ADDR_WIDTH]
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- resp_valid  out  NUM_REQ  per-requester response valid, one-hot or zero
- resp_pa  out  `ADDR_WIDTH  shared response PA
- resp_status  out  2  shared response status (`MMU_STATUS_*)
- resp_ready  in  NUM_REQ  per-requester response accept
- m_req_valid  out  1  to simple_mmu mmu_req_valid
- m_req_va  out  `ADDR_WIDTH  to mmu_req_va
- m_req_ready  in  1  from mmu_req_ready
- m_resp_valid  in  1  from mmu_resp_valid
- m_resp_pa  in  `ADDR_WIDTH  from mmu_resp_pa
- m_resp_status  in  2  from mmu_resp_status
- m_resp_ready  out  1  to mmu_resp_ready
- busy  out  1  high in any state other than IDLE

Behaviour:
- Single clock clk. Reset is asynchronous, active-low (rst_n); all state clears immediately on assertion.
- Reset values:
  - state = IDLE, rr_ptr = 0, owner = 0, held_va = 0.
  - All outputs 0; resp_status = `MMU_STATUS_HIT.
  - Reset mid-transaction abandons the transaction silently; the MMU is reset by the same rst_n.
- States: IDLE, ISSUE, WAIT, plus DRAIN (feature only).
- IDLE:
  - Winner = first k with req_valid[k], searching from rr_ptr upward with wrap at NUM_REQ-1 -> 0.
  - req_ready[winner] = 1 combinationally in the same cycle; all other req_ready bits are 0.
  - On the accept edge: held_va <= req_va[winner], owner <= winner, go to ISSUE.
  - No valid requester: stay in IDLE, rr_ptr unchanged.
- ISSUE:
  - m_req_valid = 1, m_req_va = held_va; both held stable until m_req_ready.
  - On m_req_valid && m_req_ready: go to WAIT.
  - req_ready = 0 for all requesters.
- WAIT:
  - resp_valid[owner] = m_resp_valid; other bits 0.
  - resp_pa = m_resp_pa, resp_status = m_resp_status, m_resp_ready = resp_ready[owner]. All combinational pass-through.
  - On the handshake: go to IDLE, rr_ptr <= owner+1 (wrap to 0 after NUM_REQ-1).
- Latency: accept edge -> m_req_valid is 1 cycle. Minimum accept-to-accept spacing is 3 cycles (IDLE, ISSUE, WAIT on a same-cycle MMU hit response).
- Fairness: a continuously valid requester is granted within NUM_REQ transactions.
- Per-requester ordering is trivially preserved (one outstanding translation).
- Simultaneous valids in IDLE: only the winner sees ready; losers must hold valid and VA stable.
- req_valid dropping while not granted is legal and carries no penalty.
- resp_ready[owner] held low: stay in WAIT with response passed through unchanged (backpressure reaches the MMU).
- busy = (state != IDLE).

Optional Feature:
- Macro: MMU_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle with no m_resp_valid.
  - When it reaches TIMEOUT_CYCLES, the arbiter drives resp_valid[owner] = 1, resp_pa = 0 and resp_status = `MMU_STATUS_PAGE_FAULT from registers, holding them until resp_ready[owner].
  - It then goes to DRAIN: m_resp_ready = 1 and all resp_valid = 0, until one m_resp_valid is absorbed; then IDLE with rr_ptr advanced.
  - A real response arriving in the same cycle the count hits the limit wins; no timeout is issued.
- Undefined: no counter and no DRAIN state; WAIT lasts indefinitely.

Test Plan:
- Req0 only, VA 0x0000_1234, cold TLB -> 1 cycle later m_req_va = 0x0000_1234. After the PTW delay, resp_valid = 2'b01, resp_pa = 0x0000_B234, status = `MMU_STATUS_MISS. Repeat the same VA -> status `MMU_STATUS_HIT, same PA.
- Req0 and req1 valid in the same cycle after reset (rr_ptr = 0) -> req0 granted first, then req1 (VA 0x0000_2010 -> PA 0x0000_C010). rr_ptr ends at 0.
- Both requesters continuously valid for 6 transactions -> grant order 0,1,0,1,0,1. Never two outstanding MMU requests.
- resp_ready[owner] low for 5 cycles -> resp_valid and resp_pa held stable, m_resp_ready = 0, no new grant. Then ready goes high -> IDLE.
- VA 0x0001_0000 (VPN 16) -> resp_status = `MMU_STATUS_PAGE_FAULT, resp_pa = 0, delivered only to the owner.
- rst_n pulled low while in WAIT -> all outputs 0 asynchronously; after release, a new request from req1 is granted normally.
